// File: rtl/clint_if.sv
`default_nettype none
// clint_if: request/response bus plus interrupt and trace levels of clint_timer (rev 1.0).
interface clint_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mtip_o;
  logic        msip_o;
  logic [63:0] mtime_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mtip_o, msip_o, mtime_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mtip_o, msip_o, mtime_o
  );
endinterface
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// clint_timer: memory-mapped mtime/mtimecmp/msip with prescaled tick and registered
// interrupt levels behind a single-outstanding valid/ready port (rev 1.0).
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic   clk,
  input  logic   rst,
  clint_if.slave bus
);
  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
  localparam logic [15:0] PRE_LAST     = 16'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        accept, req_ready, rsp_valid;
  logic [15:0] pre;
  logic        tick;
  logic [63:0] mtime, mtimecmp, mtime_inc, mtime_nxt, mtimecmp_nxt;
  logic        msip, msip_nxt;
  logic [63:0] rsp_rdata, rdata_nxt;
  logic        rsp_err;
  logic        mtip_q, msip_q;
  logic [63:0] offset, wmask;
  logic        in_window, aligned, sel_msip, sel_cmp, sel_mtime, addr_ok, wr;

  // Window check is done on the offset so a BASE_ADDR near the top of memory cannot overflow.
  always_comb begin
    offset    = bus.req_addr_i - BASE_ADDR;
    in_window = (bus.req_addr_i >= BASE_ADDR) && (offset[63:16] == 48'd0);
    aligned   = (bus.req_addr_i[2:0] == 3'b000);
    sel_msip  = in_window && aligned && (offset[15:0] == OFF_MSIP);
    sel_cmp   = in_window && aligned && (offset[15:0] == OFF_MTIMECMP);
    sel_mtime = in_window && aligned && (offset[15:0] == OFF_MTIME);
    addr_ok   = sel_msip || sel_cmp || sel_mtime;
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++) begin
      wmask[8*i +: 8] = {8{bus.req_wstrb_i[i]}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) begin
          accept    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A same-edge write overrides only its strobed bytes; the rest keep the ticked value.
  always_comb begin
    tick         = (pre == PRE_LAST);
    mtime_inc    = mtime + {63'd0, tick};
    wr           = accept && bus.req_we_i;
    mtime_nxt    = (wr && sel_mtime) ? ((bus.req_wdata_i & wmask) | (mtime_inc & ~wmask))
                                     : mtime_inc;
    mtimecmp_nxt = (wr && sel_cmp) ? ((bus.req_wdata_i & wmask) | (mtimecmp & ~wmask))
                                   : mtimecmp;
    msip_nxt     = (wr && sel_msip && bus.req_wstrb_i[0]) ? bus.req_wdata_i[0] : msip;
  end

  always_comb begin
    rdata_nxt = '0;
    if (!bus.req_we_i) begin
      if (sel_msip)       rdata_nxt = {63'd0, msip};
      else if (sel_cmp)   rdata_nxt = mtimecmp;
      else if (sel_mtime) rdata_nxt = mtime;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mtip_q    <= 1'b0;
      msip_q    <= 1'b0;
    end else begin
      pre      <= tick ? 16'd0 : pre + 16'd1;
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      msip     <= msip_nxt;
      mtip_q   <= (mtime >= mtimecmp);
      msip_q   <= msip;
      if (accept) begin
        rsp_rdata <= rdata_nxt;
        rsp_err   <= !addr_ok;
      end
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.mtip_o      = mtip_q;
  assign bus.msip_o      = msip_q;
  assign bus.mtime_o     = mtime;
endmodule
`default_nettype wire

// File: tb/tb_clint_timer.sv
`default_nettype none
// tb_clint_timer: two instances (TICK_DIV 1 and 4) share one request stream; a
// time-based reference model feeds a response scoreboard and per-cycle level checks.
module tb_clint_timer;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam int TD0 = 1;
  localparam int TD1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_ready = 1'b0;

  clint_if bus0 ();
  clint_if bus1 ();

  assign bus0.req_valid_i = req_valid;
  assign bus0.req_we_i    = req_we;
  assign bus0.req_addr_i  = req_addr;
  assign bus0.req_wdata_i = req_wdata;
  assign bus0.req_wstrb_i = req_wstrb;
  assign bus0.rsp_ready_i = rsp_ready;
  assign bus1.req_valid_i = req_valid;
  assign bus1.req_we_i    = req_we;
  assign bus1.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;
  assign bus1.req_wstrb_i = req_wstrb;
  assign bus1.rsp_ready_i = rsp_ready;

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [63:0] mt [2];
  logic [63:0] rdata [2];
  logic        mtip [2], msip [2], rvalid [2], rerr [2], rready [2];
  assign mt[0] = bus0.mtime_o;      assign mt[1] = bus1.mtime_o;
  assign rdata[0] = bus0.rsp_rdata_o; assign rdata[1] = bus1.rsp_rdata_o;
  assign mtip[0] = bus0.mtip_o;     assign mtip[1] = bus1.mtip_o;
  assign msip[0] = bus0.msip_o;     assign msip[1] = bus1.msip_o;
  assign rvalid[0] = bus0.rsp_valid_o; assign rvalid[1] = bus1.rsp_valid_o;
  assign rerr[0] = bus0.rsp_err_o;  assign rerr[1] = bus1.rsp_err_o;
  assign rready[0] = bus0.req_ready_o; assign rready[1] = bus1.req_ready_o;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock edges since reset release; the prescaler phase is a pure function of this.
  int ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Model: mtime is an anchor value plus the ticks elapsed since the anchor edge.
  logic [63:0] m_base [2];
  int          m_ebase [2];
  logic [63:0] m_cmp [2];
  logic        m_msip [2];

  function automatic int tdiv(input int d);
    return (d == 0) ? TD0 : TD1;
  endfunction

  function automatic logic [63:0] mtime_at(input int d, input int e);
    return m_base[d] + 64'(e / tdiv(d) - m_ebase[d] / tdiv(d));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] st);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_base[d]  = '0;
      m_ebase[d] = 0;
      m_cmp[d]   = '1;
      m_msip[d]  = 1'b0;
    end
  endtask

  task automatic model_access(input int d, input bit we, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] wstrb, input int e,
                              output logic [63:0] rd, output logic err);
    logic [63:0] off;
    off = addr - BASE;
    err = (addr < BASE) || (off >= 64'h10000) || (addr[2:0] != 3'd0) ||
          !(off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
    rd = '0;
    if (!err) begin
      if (!we) begin
        if (off == 64'h0)         rd = {63'd0, m_msip[d]};
        else if (off == 64'h4000) rd = m_cmp[d];
        else                      rd = mtime_at(d, e - 1);
      end else if (off == 64'h0) begin
        if (wstrb[0]) m_msip[d] = wdata[0];
      end else if (off == 64'h4000) begin
        m_cmp[d] = merge(m_cmp[d], wdata, wstrb);
      end else begin
        m_base[d]  = merge(mtime_at(d, e), wdata, wstrb);
        m_ebase[d] = e;
      end
    end
  endtask

  typedef struct packed {
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic        err0;
    logic        err1;
  } exp_t;
  exp_t sb[$];

  // Response monitor: pops once per response, then rechecks every cycle it is held.
  exp_t cur;
  bit   have = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      have = 1'b0;
    end else if (rvalid[0] || rvalid[1]) begin
      if (!have) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got a response with no request pending at %0t", $time);
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
        end
      end
      if (have) begin
        check("rsp_valid0", {63'd0, rvalid[0]}, 64'd1);
        check("rsp_valid1", {63'd0, rvalid[1]}, 64'd1);
        check("rsp_rdata0", rdata[0], cur.rd0);
        check("rsp_rdata1", rdata[1], cur.rd1);
        check("rsp_err0", {63'd0, rerr[0]}, {63'd0, cur.err0});
        check("rsp_err1", {63'd0, rerr[1]}, {63'd0, cur.err1});
      end
    end else begin
      have = 1'b0;
    end
  end

  // Level checker: outputs after edge e reflect model state after edge e-1.
  logic ge_prev [2];
  logic sip_prev [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ge_prev[d]  = 1'b0;
        sip_prev[d] = 1'b0;
      end else begin
        check($sformatf("mtime_o%0d", d), mt[d], mtime_at(d, ecnt));
        check($sformatf("mtip_o%0d", d), {63'd0, mtip[d]}, {63'd0, ge_prev[d]});
        check($sformatf("msip_o%0d", d), {63'd0, msip[d]}, {63'd0, sip_prev[d]});
        ge_prev[d]  = (mtime_at(d, ecnt) >= m_cmp[d]);
        sip_prev[d] = m_msip[d];
      end
    end
  end

  int rdy_mode = 2;  // 0 random, 1 held low, 2 held high
  always @(negedge clk) begin
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  logic [63:0] post_mtime;

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(rready[0] && rready[1]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: req_ready_o stayed 0 for %0d cycles", name, n);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, input bit wait_done);
    int   e_acc;
    exp_t x;
    logic [63:0] rd;
    logic        er;
    wait_idle("accept_timeout");
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    e_acc     = ecnt + 1;
    @(posedge clk);
    model_access(0, we, addr, wdata, wstrb, e_acc, rd, er);
    x.rd0 = rd; x.err0 = er;
    model_access(1, we, addr, wdata, wstrb, e_acc, rd, er);
    x.rd1 = rd; x.err1 = er;
    sb.push_back(x);
    @(negedge clk);
    post_mtime = mt[0];
    req_valid  = 1'b0;
    if (wait_done) wait_idle("retire_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d responses pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int hi0, hi1, n;
    logic [63:0] off, wd;
    logic [7:0]  st;
    model_reset();

    // Idle counting from reset.
    rdy_mode = 2;
    do_reset();
    repeat (10) @(negedge clk);
    check("idle_mtime_td1", mt[0], 64'd10);
    check("idle_mtime_td4", mt[1], 64'd2);
    check("idle_mtip", {62'd0, mtip[0], mtip[1]}, 64'd0);
    check("idle_msip", {62'd0, msip[0], msip[1]}, 64'd0);
    check("idle_ready", {62'd0, rready[0], rready[1]}, 64'd3);

    // msip set, read back, clear.
    do_req(1'b1, BASE, 64'h1, 8'hFF, 1'b1);
    check("msip_set", {62'd0, msip[0], msip[1]}, 64'd3);
    do_req(1'b0, BASE, 64'h0, 8'h00, 1'b1);
    do_req(1'b1, BASE, 64'h0, 8'hFF, 1'b1);
    check("msip_clr", {62'd0, msip[0], msip[1]}, 64'd0);

    // mtimecmp crossing and clearing.
    do_reset();
    @(negedge clk);
    do_req(1'b1, BASE + 64'h4000, 64'd5, 8'hFF, 1'b1);
    n = 0;
    while (ecnt < 25 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmp5_mtip", {62'd0, mtip[0], mtip[1]}, 64'd3);
    do_req(1'b1, BASE + 64'h4000, 64'd100, 8'hFF, 1'b1);
    check("cmp100_mtip", {62'd0, mtip[0], mtip[1]}, 64'd0);

    // mtime wrap with mtimecmp at its reset value.
    do_reset();
    @(negedge clk);
    do_req(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1);
    hi0 = 0;
    hi1 = 0;
    repeat (16) begin
      @(negedge clk);
      hi0 += int'(mtip[0]);
      hi1 += int'(mtip[1]);
    end
    check("wrap_pulse_td1", 64'(hi0), 64'd1);
    check("wrap_pulse_td4", 64'(hi1), 64'd4);

    // Unmapped / misaligned / out-of-window accesses.
    rdy_mode = 0;
    do_req(1'b1, BASE + 64'h4, 64'hDEAD, 8'hFF, 1'b1);
    do_req(1'b0, BASE + 64'h1000, 64'h0, 8'h00, 1'b1);
    do_req(1'b1, BASE + 64'h10000, 64'h1, 8'hFF, 1'b1);
    do_req(1'b0, BASE + 64'h10000, 64'h0, 8'h00, 1'b1);
    do_req(1'b0, BASE + 64'h4000, 64'h0, 8'h00, 1'b1);

    // Response held under back-pressure, then reset in RESP.
    rdy_mode = 1;
    @(negedge clk);
    do_req(1'b0, BASE + 64'h4000, 64'h0, 8'h00, 1'b0);
    repeat (3) begin
      check("hold_valid", {62'd0, rvalid[0], rvalid[1]}, 64'd3);
      check("hold_ready", {62'd0, rready[0], rready[1]}, 64'd0);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_valid", {62'd0, rvalid[0], rvalid[1]}, 64'd0);
    check("rst_ready", {62'd0, rready[0], rready[1]}, 64'd3);
    @(negedge clk);
    #2 rst = 1'b0;
    rdy_mode = 2;

    // Partial-strobe mtime write landing on a tick edge.
    @(negedge clk);
    do_req(1'b1, BASE + 64'hBFF8, 64'h0000_0001_FFFF_FFFE, 8'hFF, 1'b1);
    do_req(1'b1, BASE + 64'hBFF8, 64'hAAAA_AAAA_1234_5678, 8'h0F, 1'b1);
    check("wstrb_tick_mtime", post_mtime, 64'h0000_0002_1234_5678);

    // Randomized traffic.
    do_reset();
    rdy_mode = 0;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    off = 64'h0;
        2, 3:    off = 64'h4000;
        4, 5, 6: off = 64'hBFF8;
        7:       off = ($urandom_range(0, 1) == 0) ? 64'h1000 : 64'hBFFC;
        8:       off = 64'h10000;
        default: off = 64'hFFFF_FFFF_FFFF_FFF8;
      endcase
      case ($urandom_range(0, 3))
        0:       wd = {$urandom(), $urandom()};
        1:       wd = mtime_at(1, ecnt) + 64'($urandom_range(0, 12));
        2:       wd = mtime_at(0, ecnt) + 64'($urandom_range(0, 30));
        default: wd = 64'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       st = 8'h00;
        1:       st = 8'($urandom());
        default: st = 8'hFF;
      endcase
      do_req($urandom_range(0, 1) == 1, BASE + off, wd, st, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/clint_timer.md
# clint_timer

Machine-level timer and software-interrupt source for the core's interrupt path. Holds `mtime`, `mtimecmp` and `msip` as memory-mapped registers behind a single-outstanding valid/ready slave port. Drives registered `mtip_o`/`msip_o` levels to the interrupt-entry logic that selects `mtvec` and writes `mepc`/`mcause`/`mstatus`. Timer ticks come from an internal prescaler.

## Interface
- `BASE_ADDR`, default 64'h0000_0000_0200_0000: base of the 64 KiB register window.
- `TICK_DIV`, default 1: clk cycles per `mtime` increment; legal range 1..65535.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: block can accept a request.
- `req_we_i`, input, 1: 1 = write, 0 = read.
- `req_addr_i`, input, 64: byte address.
- `req_wdata_i`, input, 64: write data.
- `req_wstrb_i`, input, 8: byte enables; bit n covers bits [8n+7:8n].
- `rsp_valid_o`, output, 1: response valid.
- `rsp_ready_i`, input, 1: consumer accepts response.
- `rsp_rdata_o`, output, 64: read data; 0 for writes and for errors.
- `rsp_err_o`, output, 1: access was unmapped or misaligned.
- `mtip_o`, output, 1: machine timer interrupt pending (level).
- `msip_o`, output, 1: machine software interrupt pending (level).
- `mtime_o`, output, 64: current `mtime`, for trace and difftest.

## Operation
- Register map, offsets from `BASE_ADDR`. All accesses are 8-byte aligned doublewords.
  - 0x0000 `msip`: bit 0 is read/write; bits 63:1 read 0 and ignore writes.
  - 0x4000 `mtimecmp`: 64-bit read/write.
  - 0xBFF8 `mtime`: 64-bit read/write.
- Error response: any other offset, `req_addr_i[2:0]` != 0, or an address outside the window. Response has `rsp_err_o`=1 and `rsp_rdata_o`=0. No state changes.
- Handshake FSM with two states, IDLE and RESP:
  - IDLE: `req_ready_o`=1. If `req_valid_i`=1, the request is accepted on that edge and the FSM moves to RESP.
  - RESP: `req_ready_o`=0, `rsp_valid_o`=1. `rsp_rdata_o`/`rsp_err_o` are stable until a cycle with `rsp_ready_i`=1; that edge returns the FSM to IDLE.
  - Only one transaction is outstanding. There is no back-to-back accept in the cycle a response retires.
- Reads capture the register value at the accept edge, before any same-edge tick.
- Writes commit at the accept edge. Only bytes with `req_wstrb_i`=1 are written. `wstrb`=0 is a legal no-op write with a normal response.
- Prescaler:
  - Counter `pre` counts 0..TICK_DIV-1.
  - On a cycle where `pre`==TICK_DIV-1: `pre` returns to 0 and `mtime` increments by 1.
  - `mtime` wraps from 2^64-1 to 0 with no flag.
- Simultaneous tick and `mtime` write: the written bytes take the write data. Unwritten bytes take the incremented value's bytes. The prescaler is not disturbed.
- `mtip_o` is registered: mtip_o <= (mtime >= mtimecmp), an unsigned 64-bit compare using current register values.
- `msip_o` is registered from `msip[0]`.
- Reset values:
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `pre`=0.
  - FSM=IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mtip_o`=0, `msip_o`=0, `mtime_o`=0.
- Reset mid-transaction: the pending response is dropped and the FSM returns to IDLE immediately.

## Timing
- Request accept to `rsp_valid_o`: 1 cycle, visible the cycle after the accept edge.
- Register write to `msip_o` change: 1 cycle after the accept edge.
- `mtimecmp`/`mtime` write to `mtip_o` update: 1 cycle after the accept edge. Clearing by writing a larger `mtimecmp` deasserts `mtip_o` the cycle after commit.
- `mtime` reaching `mtimecmp` to `mtip_o`=1: 1 cycle.
- Tick period: exactly TICK_DIV clk cycles. The first increment after reset occurs at the end of cycle TICK_DIV.
- `mtime_o` is the register output with no extra delay.

## Test plan
- Reset, TICK_DIV=1, no requests for 10 cycles -> `mtime_o`=10, `mtip_o`=0, `msip_o`=0, `req_ready_o`=1.
- Write 1 to `msip` (offset 0x0000, wstrb 8'hFF), then read it back -> `msip_o`=1 one cycle after accept; read returns 64'h1 with `rsp_err_o`=0. Write 0 -> `msip_o`=0.
- TICK_DIV=4, write `mtimecmp`=5 -> `mtip_o` rises exactly 1 cycle after `mtime` becomes 5 (about 20 cycles after reset). Writing `mtimecmp`=100 drops `mtip_o` the cycle after the write.
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 -> after 2 ticks `mtime_o`=0. With `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `mtip_o` is 1 for exactly 1 cycle.
- Accesses at 0x0004, 0x1000 and `BASE_ADDR`+0x10000 -> `rsp_err_o`=1, `rsp_rdata_o`=0, no register change. Hold `rsp_ready_i`=0 for 3 cycles -> `rsp_valid_o` and data held and `req_ready_o`=0 throughout.
- Write `mtime` with wstrb 8'h0F and data 64'hAAAA_AAAA_1234_5678 on a tick edge with old `mtime`=64'h0000_0001_FFFF_FFFF -> result `mtime`=64'h0000_0002_1234_5678. Assert `rst` while in RESP -> `rsp_valid_o`=0 the same cycle.
